// File: rtl/lpc_bios_wd_reg_pkg.sv
// Shared encodings for the LPC BIOS watchdog register slice:
// FSM states, LPC cycle types, register offsets and bus constants.
`default_nettype none

package lpc_bios_wd_reg_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_CYCTYPE = 4'd1,
      ST_ADDR    = 4'd2,
      ST_WDATA   = 4'd3,
      ST_HTAR    = 4'd4,
      ST_SYNC    = 4'd5,
      ST_RDATA   = 4'd6,
      ST_PTAR    = 4'd7,
      ST_SKIP    = 4'd8
   } lpc_state_e;

   localparam logic [2:0]  CYC_IO_RD      = 3'b000;
   localparam logic [2:0]  CYC_IO_WR      = 3'b001;

   localparam logic [15:0] OFS_WD         = 16'h0000;
   localparam logic [15:0] OFS_STATUS     = 16'h0001;

   localparam logic [3:0]  LPC_START      = 4'h0;
   localparam logic [3:0]  LPC_ABORT      = 4'hF;
   localparam logic [3:0]  LPC_SYNC_READY = 4'h0;

endpackage

`default_nettype wire

// File: rtl/lpc_bios_wd_reg_if.sv
// LPC bus bundle: host (master) drives frame/LAD, the peripheral (slave)
// drives LAD_out with its output enable.
`default_nettype none

interface lpc_bios_wd_reg_if;
   logic       LFRAMEn;
   logic [3:0] LAD_in;
   logic [3:0] LAD_out;
   logic       LAD_oe;

   modport master (output LFRAMEn, output LAD_in, input LAD_out, input LAD_oe);
   modport slave  (input LFRAMEn, input LAD_in, output LAD_out, output LAD_oe);
endinterface

`default_nettype wire

// File: rtl/lpc_io_decoder.sv
// LPC I/O cycle decoder: framing FSM, address/data shift registers and LAD drive.
`default_nettype none

module lpc_io_decoder
   import lpc_bios_wd_reg_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0600
) (
   input  wire logic            LpcClock,
   input  wire logic            MainReset,
   lpc_bios_wd_reg_if.slave     lpc,
   input  wire logic [7:0]      rd_data_i,
   output logic                 wr_strobe_o,
   output logic [7:0]           wr_data_o,
   output logic                 rd_capture_o,
   output logic                 rd_status_o
);

   localparam logic [15:0] c_ADDR_WD     = BASE_ADDR + OFS_WD;
   localparam logic [15:0] c_ADDR_STATUS = BASE_ADDR + OFS_STATUS;
   localparam logic [3:0]  c_LAD_PARK    = 4'hF;

   lpc_state_e  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [11:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        is_wr_q, is_wr_d;
   logic        sel_status_q, sel_status_d;
   logic        lad_oe_q, lad_oe_d;
   logic [3:0]  lad_out_q, lad_out_d;

   logic        w_start;
   logic        w_abort;
   logic [15:0] w_addr_full;

   assign w_start     = !lpc.LFRAMEn && (lpc.LAD_in == LPC_START);
   assign w_abort     = !lpc.LFRAMEn && (lpc.LAD_in == LPC_ABORT);
   assign w_addr_full = {addr_q, lpc.LAD_in};

   always_ff @(posedge LpcClock or negedge MainReset) begin
      if (!MainReset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 2'd0;
         addr_q       <= 12'h000;
         data_q       <= 8'h00;
         is_wr_q      <= 1'b0;
         sel_status_q <= 1'b0;
         lad_oe_q     <= 1'b0;
         lad_out_q    <= c_LAD_PARK;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         is_wr_q      <= is_wr_d;
         sel_status_q <= sel_status_d;
         lad_oe_q     <= lad_oe_d;
         lad_out_q    <= lad_out_d;
      end
   end

   // START and ABORT framing take priority over whatever the FSM is doing.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      data_d       = data_q;
      is_wr_d      = is_wr_q;
      sel_status_d = sel_status_q;
      if (w_start) begin
         state_d = ST_CYCTYPE;
         cnt_d   = 2'd0;
      end else if (w_abort) begin
         state_d = ST_IDLE;
         cnt_d   = 2'd0;
      end else if (!lpc.LFRAMEn) begin
         state_d = ST_SKIP;
         cnt_d   = 2'd0;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_CYCTYPE: begin
               cnt_d  = 2'd0;
               addr_d = 12'h000;
               if (lpc.LAD_in[3:1] == CYC_IO_RD) begin
                  is_wr_d = 1'b0;
                  state_d = ST_ADDR;
               end else if (lpc.LAD_in[3:1] == CYC_IO_WR) begin
                  is_wr_d = 1'b1;
                  state_d = ST_ADDR;
               end else begin
                  state_d = ST_SKIP;
               end
            end
            ST_ADDR: begin
               addr_d = w_addr_full[11:0];
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  cnt_d = 2'd0;
                  if (w_addr_full == c_ADDR_WD) begin
                     sel_status_d = 1'b0;
                     state_d      = is_wr_q ? ST_WDATA : ST_HTAR;
                  end else if (w_addr_full == c_ADDR_STATUS && !is_wr_q) begin
                     sel_status_d = 1'b1;
                     state_d      = ST_HTAR;
                  end else begin
                     state_d = ST_SKIP;
                  end
               end
            end
            ST_WDATA: begin
               if (cnt_q == 2'd0) begin
                  data_d[3:0] = lpc.LAD_in;
                  cnt_d       = 2'd1;
               end else begin
                  data_d[7:4] = lpc.LAD_in;
                  cnt_d       = 2'd0;
                  state_d     = ST_HTAR;
               end
            end
            ST_HTAR: begin
               if (cnt_q == 2'd0) begin
                  cnt_d = 2'd1;
               end else begin
                  cnt_d   = 2'd0;
                  state_d = ST_SYNC;
               end
            end
            ST_SYNC: begin
               cnt_d   = 2'd0;
               state_d = is_wr_q ? ST_PTAR : ST_RDATA;
            end
            ST_RDATA: begin
               if (cnt_q == 2'd0) begin
                  cnt_d = 2'd1;
               end else begin
                  cnt_d   = 2'd0;
                  state_d = ST_PTAR;
               end
            end
            ST_PTAR: begin
               if (cnt_q == 2'd0) begin
                  cnt_d = 2'd1;
               end else begin
                  cnt_d   = 2'd0;
                  state_d = ST_IDLE;
               end
            end
            ST_SKIP: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Drive values are decoded from the next state so LAD is registered yet
   // lines up with the state it belongs to.
   always_comb begin
      lad_oe_d  = 1'b0;
      lad_out_d = c_LAD_PARK;
      case (state_d)
         ST_SYNC: begin
            lad_oe_d  = 1'b1;
            lad_out_d = LPC_SYNC_READY;
         end
         ST_RDATA: begin
            lad_oe_d  = 1'b1;
            lad_out_d = (cnt_d == 2'd0) ? rd_data_i[3:0] : rd_data_i[7:4];
         end
         ST_PTAR: begin
            if (cnt_d == 2'd0) begin
               lad_oe_d  = 1'b1;
               lad_out_d = c_LAD_PARK;
            end
         end
         default: ;
      endcase
      wr_strobe_o  = (state_q == ST_HTAR) && (state_d == ST_SYNC) && is_wr_q;
      rd_capture_o = (state_q == ST_HTAR) && (state_d == ST_SYNC) && !is_wr_q;
   end

   assign wr_data_o   = data_q;
   assign rd_status_o = sel_status_q;
   assign lpc.LAD_oe  = lad_oe_q;
   assign lpc.LAD_out = lad_out_q;

endmodule

`default_nettype wire

// File: rtl/lpc_bios_wd_reg.sv
// BIOS watchdog register on LPC I/O: WD control at BASE_ADDR, status at BASE_ADDR+1.
`default_nettype none

module lpc_bios_wd_reg
   import lpc_bios_wd_reg_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0600
) (
   input  wire logic            LpcClock,
   input  wire logic            MainReset,
   lpc_bios_wd_reg_if.slave     lpc,
   input  wire logic            BiosFinished,
   input  wire logic            ForceSwap,
   input  wire logic            BiosPowerOff,
   output logic [7:0]           BiosRegister,
   output logic                 WriteBiosWD
);

   logic [7:0] bios_q;
   logic       strobe_q;
   logic [7:0] rd_data_q;

   logic       w_wr_strobe;
   logic [7:0] w_wr_data;
   logic       w_rd_capture;
   logic       w_rd_status;
   logic [7:0] w_status;
   logic [7:0] w_rd_mux;

   lpc_io_decoder #(
      .BASE_ADDR (BASE_ADDR)
   ) u_dec (
      .LpcClock     (LpcClock),
      .MainReset    (MainReset),
      .lpc          (lpc),
      .rd_data_i    (rd_data_q),
      .wr_strobe_o  (w_wr_strobe),
      .wr_data_o    (w_wr_data),
      .rd_capture_o (w_rd_capture),
      .rd_status_o  (w_rd_status)
   );

   assign w_status = {5'b00000, BiosPowerOff, ForceSwap, BiosFinished};
   assign w_rd_mux = w_rd_status ? w_status : bios_q;

   // Register, strobe and read snapshot all land on the edge entering SYNC.
   always_ff @(posedge LpcClock or negedge MainReset) begin
      if (!MainReset) begin
         bios_q    <= 8'h00;
         strobe_q  <= 1'b0;
         rd_data_q <= 8'h00;
      end else begin
         strobe_q <= w_wr_strobe;
         if (w_wr_strobe) begin
            bios_q <= w_wr_data;
         end
         if (w_rd_capture) begin
            rd_data_q <= w_rd_mux;
         end
      end
   end

   assign BiosRegister = bios_q;
   assign WriteBiosWD  = strobe_q;

endmodule

`default_nettype wire

// File: tb/tb_lpc_bios_wd_reg.sv
// Directed bench for lpc_bios_wd_reg: LPC I/O reads/writes, aborts and reset.
`timescale 1ns/1ps
`default_nettype none

module tb_lpc_bios_wd_reg;

   logic       LpcClock = 1'b0;
   logic       MainReset = 1'b1;
   logic       BiosFinished = 1'b0;
   logic       ForceSwap = 1'b0;
   logic       BiosPowerOff = 1'b0;
   logic [7:0] BiosRegister;
   logic       WriteBiosWD;

   lpc_bios_wd_reg_if lpc();

   lpc_bios_wd_reg #(.BASE_ADDR(16'h0600)) dut (
      .LpcClock     (LpcClock),
      .MainReset    (MainReset),
      .lpc          (lpc),
      .BiosFinished (BiosFinished),
      .ForceSwap    (ForceSwap),
      .BiosPowerOff (BiosPowerOff),
      .BiosRegister (BiosRegister),
      .WriteBiosWD  (WriteBiosWD)
   );

   always #15 LpcClock = ~LpcClock;

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;
   int tx_start = 0;
   int n_strobe, n_oe, first_strobe, last_strobe;
   logic [3:0] lad_log [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic clr_obs();
      n_strobe     = 0;
      n_oe         = 0;
      first_strobe = -1;
      last_strobe  = -1;
      for (int i = 0; i < 16; i++) lad_log[i] = 4'hF;
   endtask

   // One bus clock: drive at negedge, observe registered outputs just after posedge.
   task automatic step(input logic lf, input logic [3:0] lad);
      @(negedge LpcClock);
      lpc.LFRAMEn = lf;
      lpc.LAD_in  = lad;
      @(posedge LpcClock);
      #1;
      cyc++;
      if (WriteBiosWD === 1'b1) begin
         if (n_strobe == 0) first_strobe = cyc;
         last_strobe = cyc;
         n_strobe++;
      end
      if (lpc.LAD_oe === 1'b1) begin
         if (n_oe < 16) lad_log[n_oe] = lpc.LAD_out;
         n_oe++;
      end
   endtask

   task automatic lpc_io(input bit wr, input logic [15:0] addr, input logic [7:0] data,
                         input int tail);
      step(1'b0, 4'h0);
      tx_start = cyc;
      step(1'b1, wr ? 4'h2 : 4'h0);
      for (int i = 0; i < 4; i++) step(1'b1, addr[15-4*i -: 4]);
      if (wr) begin
         step(1'b1, data[3:0]);
         step(1'b1, data[7:4]);
      end
      for (int i = 0; i < tail; i++) step(1'b1, 4'hF);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      lpc.LFRAMEn = 1'b1;
      lpc.LAD_in  = 4'hF;
      #2 MainReset = 1'b0;
      #5;
      chk("reset reg",    {24'h0, BiosRegister}, 32'h00);
      chk("reset strobe", {31'h0, WriteBiosWD},  32'h0);
      chk("reset oe",     {31'h0, lpc.LAD_oe},   32'h0);
      chk("reset out",    {28'h0, lpc.LAD_out},  32'hF);
      @(negedge LpcClock);
      MainReset = 1'b1;
      step(1'b1, 4'hF);

      // write 0x55 to 0x0600
      clr_obs();
      lpc_io(1'b1, 16'h0600, 8'h55, 5);
      step(1'b1, 4'hF);
      chk("wr55 strobes",    n_strobe, 1);
      chk("wr55 strobe clk", first_strobe - tx_start + 1, 10);
      chk("wr55 reg",        {24'h0, BiosRegister}, 32'h55);
      chk("wr55 oe clocks",  n_oe, 2);
      chk("wr55 sync",       {28'h0, lad_log[0]}, 32'h0);
      chk("wr55 ptar",       {28'h0, lad_log[1]}, 32'hF);

      // status read of 0x0601: {PowerOff=1, ForceSwap=0, Finished=1} = 0x05
      BiosFinished = 1'b1;
      ForceSwap    = 1'b0;
      BiosPowerOff = 1'b1;
      clr_obs();
      lpc_io(1'b0, 16'h0601, 8'h00, 7);
      step(1'b1, 4'hF);
      chk("rd601 oe clocks", n_oe, 4);
      chk("rd601 sync",      {28'h0, lad_log[0]}, 32'h0);
      chk("rd601 lo",        {28'h0, lad_log[1]}, 32'h5);
      chk("rd601 hi",        {28'h0, lad_log[2]}, 32'h0);
      chk("rd601 ptar",      {28'h0, lad_log[3]}, 32'hF);
      chk("rd601 strobes",   n_strobe, 0);

      // read back the WD register
      clr_obs();
      lpc_io(1'b0, 16'h0600, 8'h00, 7);
      step(1'b1, 4'hF);
      chk("rd600 lo", {28'h0, lad_log[1]}, 32'h5);
      chk("rd600 hi", {28'h0, lad_log[2]}, 32'h5);

      // address miss: 0x29 to 0x0700
      clr_obs();
      lpc_io(1'b1, 16'h0700, 8'h29, 5);
      step(1'b1, 4'hF);
      chk("miss strobes", n_strobe, 0);
      chk("miss oe",      n_oe, 0);
      chk("miss reg",     {24'h0, BiosRegister}, 32'h55);

      // write to read-only status offset
      clr_obs();
      lpc_io(1'b1, 16'h0601, 8'h29, 5);
      step(1'b1, 4'hF);
      chk("wrsts strobes", n_strobe, 0);
      chk("wrsts oe",      n_oe, 0);
      chk("wrsts reg",     {24'h0, BiosRegister}, 32'h55);

      // abort after first data nibble, then a full write of 0xFF
      clr_obs();
      step(1'b0, 4'h0);
      step(1'b1, 4'h2);
      step(1'b1, 4'h0); step(1'b1, 4'h6); step(1'b1, 4'h0); step(1'b1, 4'h0);
      step(1'b1, 4'h9);
      step(1'b0, 4'hF);
      for (int i = 0; i < 6; i++) step(1'b1, 4'hF);
      chk("abort strobes", n_strobe, 0);
      chk("abort oe",      n_oe, 0);
      chk("abort reg",     {24'h0, BiosRegister}, 32'h55);
      clr_obs();
      lpc_io(1'b1, 16'h0600, 8'hFF, 5);
      step(1'b1, 4'hF);
      chk("wrFF strobes", n_strobe, 1);
      chk("wrFF reg",     {24'h0, BiosRegister}, 32'hFF);

      // reset pulse during HTAR of a 0xAA write
      clr_obs();
      step(1'b0, 4'h0);
      step(1'b1, 4'h2);
      step(1'b1, 4'h0); step(1'b1, 4'h6); step(1'b1, 4'h0); step(1'b1, 4'h0);
      step(1'b1, 4'hA); step(1'b1, 4'hA);
      step(1'b1, 4'hF);
      #5 MainReset = 1'b0;
      #2;
      chk("rst reg",    {24'h0, BiosRegister}, 32'h00);
      chk("rst strobe", {31'h0, WriteBiosWD},  32'h0);
      chk("rst oe",     {31'h0, lpc.LAD_oe},   32'h0);
      @(negedge LpcClock);
      MainReset = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b1, 4'hF);
      chk("rst strobes", n_strobe, 0);
      chk("rst oe seen", n_oe, 0);
      chk("rst reg2",    {24'h0, BiosRegister}, 32'h00);
      clr_obs();
      lpc_io(1'b0, 16'h0600, 8'h00, 7);
      step(1'b1, 4'hF);
      chk("rst rd oe", n_oe, 4);
      chk("rst rd lo", {28'h0, lad_log[1]}, 32'h0);
      chk("rst rd hi", {28'h0, lad_log[2]}, 32'h0);

      // back-to-back writes: next START in the final PTAR clock
      clr_obs();
      lpc_io(1'b1, 16'h0600, 8'h01, 4);
      lpc_io(1'b1, 16'h0600, 8'h02, 5);
      step(1'b1, 4'hF);
      step(1'b1, 4'hF);
      chk("b2b strobes", n_strobe, 2);
      chk("b2b gap",     last_strobe - first_strobe, 12);
      chk("b2b oe",      n_oe, 4);
      chk("b2b reg",     {24'h0, BiosRegister}, 32'h02);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
